io_responder: RTL

- Peripheral that answers the CPU's IO requests: `opIo` plus stall via `waitFlag`.
- IN: holds the CPU stalled until the operator presses the insert button, then returns the zero-extended switch value on `sIo`.
- OUT: captures the CPU data word and shows it as 4 decimal digits on the HEX3..HEX0 7-segment displays, using a sequential binary-to-BCD converter.
- Sits between the CPU datapath (`opIo`, `dataOut`, `sIo`, `waitFlag`) and the board I/O (switches, key, displays).

---
 rtl/io_responder.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/io_responder.sv
// io_responder: answers CPU IO requests. IN stalls the CPU until the operator
// presses the insert key and then returns the switch value. OUT shows the CPU
// data word as four decimal digits on HEX3..HEX0.
module io_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int SW_WIDTH   = 18,
  parameter int DEB_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            opIo,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  button,
  input  logic [DATA_WIDTH-1:0] dataOut,
  output logic [DATA_WIDTH-1:0] sIo,
  output logic                  waitFlag,
  output logic [27:0]           displays,
  output logic                  busy
);

  // Input FSM
  //   state     | meaning
  //   S_IDLE    | no IN pending
  //   S_ARMED   | IN pending, waiting for a fresh key press
  //   S_ACK     | one cycle: sIo valid, CPU released
  //   S_RELEASE | waiting for the key to be let go before re-arming
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACK, S_RELEASE} in_state_t;

  // Display converter phases
  typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_WRITE, C_DASH} conv_t;

  localparam logic [1:0] OP_IN  = 2'b01;
  localparam logic [1:0] OP_OUT = 2'b10;

  localparam int             DCW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCW-1:0] DEB_LOAD = DCW'(DEB_CYCLES - 1);

  localparam logic [6:0] SEG_ZERO = 7'b0000001;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_DASH;
    endcase
  endfunction

  // ---------------------------------------------------------------- reset
  logic rst_meta_q, rst_meta_d, rst_sync_q, rst_sync_d;
  logic rst_int_n;

  // Release of the internal reset is re-timed to the clock; assertion stays asynchronous.
  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  // Reset synchronizer flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q;

  // ---------------------------------------------------------------- button
  logic           sync1_q, sync1_d, sync2_q, sync2_d;
  logic           btn_q, btn_d, press_q, press_d;
  logic [DCW-1:0] deb_cnt_q, deb_cnt_d;

  // Debounce: btn follows the synchronized key only after it has differed for DEB_CYCLES cycles.
  always_comb begin
    sync1_d   = button;
    sync2_d   = sync1_q;
    btn_d     = btn_q;
    press_d   = 1'b0;
    deb_cnt_d = DEB_LOAD;
    if (sync2_q != btn_q) begin
      if (deb_cnt_q == '0) begin
        btn_d   = sync2_q;
        press_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q - 1'b1;
      end
    end
  end

  // Button path registers.
  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      deb_cnt_q <= DEB_LOAD;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // ---------------------------------------------------------------- input FSM
  in_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] sio_q, sio_d;
  logic                  is_in;

  assign is_in = (opIo == OP_IN);

  // Input FSM state register and captured switch value.
  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_IDLE;
      sio_q   <= '0;
    end else begin
      state_q <= state_d;
      sio_q   <= sio_d;
    end
  end

  // Input FSM next state; only a press seen while armed satisfies the request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (is_in) state_d = S_ARMED;
      S_ARMED: begin
        if (!is_in)       state_d = S_IDLE;
        else if (press_q) state_d = S_ACK;
      end
      S_ACK:     state_d = btn_q ? S_RELEASE : S_IDLE;
      S_RELEASE: if (!btn_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Input FSM outputs: stall everywhere except the ACK cycle, capture on the accepting press.
  always_comb begin
    waitFlag = is_in && (state_q != S_ACK);
    sio_d    = sio_q;
    if ((state_q == S_ARMED) && is_in && press_q) sio_d = DATA_WIDTH'(switches);
  end

  assign sIo = sio_q;

  // ---------------------------------------------------------------- display converter
  conv_t       phase_q, phase_d;
  logic [3:0]  shift_cnt_q, shift_cnt_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d, bcd_adj;
  logic [27:0] disp_q, disp_d;
  logic        out_load, out_range;

  assign out_load  = (opIo == OP_OUT);
  assign out_range = (dataOut > DATA_WIDTH'(9999));

  // Converter registers.
  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      phase_q     <= C_IDLE;
      shift_cnt_q <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      disp_q      <= {4{SEG_ZERO}};
    end else begin
      phase_q     <= phase_d;
      shift_cnt_q <= shift_cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      disp_q      <= disp_d;
    end
  end

  // Converter sequencing: a new OUT always restarts, 14 shifts then one write.
  always_comb begin
    phase_d     = phase_q;
    shift_cnt_d = shift_cnt_q;
    if (out_load) begin
      phase_d     = out_range ? C_DASH : C_SHIFT;
      shift_cnt_d = 4'd13;
    end else begin
      case (phase_q)
        C_SHIFT: begin
          if (shift_cnt_q == 4'd0) phase_d = C_WRITE;
          else                     shift_cnt_d = shift_cnt_q - 4'd1;
        end
        C_WRITE, C_DASH: phase_d = C_IDLE;
        default:         phase_d = C_IDLE;
      endcase
    end
  end

  // Double-dabble datapath and display update.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    disp_d = disp_q;
    if (out_load) begin
      bin_d = dataOut[13:0];
      bcd_d = '0;
    end else begin
      case (phase_q)
        C_SHIFT: begin
          bcd_d = (bcd_adj << 1) | {15'd0, bin_q[13]};
          bin_d = bin_q << 1;
        end
        C_WRITE: disp_d = {seg7(bcd_q[15:12]), seg7(bcd_q[11:8]), seg7(bcd_q[7:4]), seg7(bcd_q[3:0])};
        C_DASH:  disp_d = {4{SEG_DASH}};
        default: ;
      endcase
    end
  end

  assign displays = disp_q;
  assign busy     = (phase_q != C_IDLE);

endmodule
